// File: rtl/seq_decoder_pkg.sv
// Shared definitions for the registered address decoder: mode encodings and
// the sizing rule for the dwell counter.
package seq_decoder_pkg;

   localparam logic MODE_LATCH = 1'b0;
   localparam logic MODE_SCAN  = 1'b1;

   // Counter must hold 0..DWELL-1; a floor of one bit keeps degenerate values legal.
   function automatic int dwell_width(input int dwell);
      if (dwell < 1) begin
         return 1;
      end
      return $clog2(dwell + 1);
   endfunction

endpackage

// File: rtl/onehot_decode.sv
// Pure combinational active-low decoder: exactly one output low when enabled,
// all outputs high otherwise.
module onehot_decode #(
   parameter int A_WIDTH = 4
) (
   input  logic [A_WIDTH-1:0]      addr,
   input  logic                    en,
   output logic [(1<<A_WIDTH)-1:0] y
);

   localparam int OUTS = 1 << A_WIDTH;

   always_comb begin
      y = '1;
      if (en) begin
         for (int i = 0; i < OUTS; i++) begin
            if (addr == A_WIDTH'(i)) begin
               y[i] = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/seq_decoder.sv
// Registered active-low select decoder: address is latched from A or stepped
// through every output in scan mode with a programmable dwell per address.
module seq_decoder
   import seq_decoder_pkg::*;
#(
   parameter int A_WIDTH = 4,
   parameter int DWELL   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    _E0,
   input  logic                    _E1,
   input  logic [A_WIDTH-1:0]      A,
   input  logic                    le,
   input  logic                    mode,
   output logic [(1<<A_WIDTH)-1:0] Y,
   output logic [A_WIDTH-1:0]      Q,
   output logic                    wrap
);

   localparam int            DW         = dwell_width(DWELL);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   logic               enabled;
   logic [A_WIDTH-1:0] addr_d,  addr_q;
   logic [DW-1:0]      dwell_d, dwell_q;
   logic               wrap_d,  wrap_q;

   assign enabled = ~_E0 & ~_E1;

   // A load always wins over a scan step, so a load can never raise wrap.
   always_comb begin
      addr_d  = addr_q;
      dwell_d = dwell_q;
      wrap_d  = 1'b0;
      if (le) begin
         addr_d  = A;
         dwell_d = '0;
      end else if ((mode == MODE_SCAN) && enabled) begin
         if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            addr_d  = addr_q + A_WIDTH'(1);
            wrap_d  = (addr_q == {A_WIDTH{1'b1}});
         end else begin
            dwell_d = dwell_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         dwell_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         dwell_q <= dwell_d;
         wrap_q  <= wrap_d;
      end
   end

   // Reset blanks the selects combinationally, independent of the register state.
   onehot_decode #(
      .A_WIDTH(A_WIDTH)
   ) u_decode (
      .addr(addr_q),
      .en  (enabled & ~reset),
      .y   (Y)
   );

   assign Q    = addr_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: three instances cover A_WIDTH=4/DWELL=1, A_WIDTH=4/DWELL=3
// and A_WIDTH=3/DWELL=2; expected outputs are queued at drive time and popped after each edge.
module tb_seq_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, reset2;
   // instance 0: A_WIDTH=4, DWELL=1
   logic        le0, mode0, ne0_0, ne1_0;
   logic [3:0]  a0;
   logic [15:0] y0;
   logic [3:0]  q0;
   logic        w0;
   // instance 1: A_WIDTH=4, DWELL=3
   logic        le1, mode1, ne0_1, ne1_1;
   logic [3:0]  a1;
   logic [15:0] y1;
   logic [3:0]  q1;
   logic        w1;
   // instance 2: A_WIDTH=3, DWELL=2
   logic        le2, mode2, ne0_2, ne1_2;
   logic [2:0]  a2;
   logic [7:0]  y2;
   logic [2:0]  q2;
   logic        w2;

   seq_decoder #(.A_WIDTH(4), .DWELL(1)) u0 (
      .clk(clk), .reset(reset), ._E0(ne0_0), ._E1(ne1_0), .A(a0), .le(le0),
      .mode(mode0), .Y(y0), .Q(q0), .wrap(w0));
   seq_decoder #(.A_WIDTH(4), .DWELL(3)) u1 (
      .clk(clk), .reset(reset), ._E0(ne0_1), ._E1(ne1_1), .A(a1), .le(le1),
      .mode(mode1), .Y(y1), .Q(q1), .wrap(w1));
   seq_decoder #(.A_WIDTH(3), .DWELL(2)) u2 (
      .clk(clk), .reset(reset2), ._E0(ne0_2), ._E1(ne1_2), .A(a2), .le(le2),
      .mode(mode2), .Y(y2), .Q(q2), .wrap(w2));

   typedef struct {
      int          inst;
      string       name;
      logic [15:0] y;
      logic [3:0]  q;
      logic        w;
   } exp_t;

   typedef struct {
      logic        le;
      logic        mode;
      logic        ne0;
      logic        ne1;
      logic [3:0]  a;
      logic [15:0] y;
      logic [3:0]  q;
      logic        w;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[13];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] yexp(input int inst, input logic [3:0] q, input logic dis);
      logic [15:0] full;
      full = dis ? 16'hFFFF : ~(16'h0001 << q);
      if (inst == 2) full = {8'h00, full[7:0]};
      return full;
   endfunction

   task automatic push(input int inst, input string name, input logic [15:0] y,
                       input logic [3:0] q, input logic w);
      exp_t e;
      e.inst = inst; e.name = name; e.y = y; e.q = q; e.w = w;
      sbq.push_back(e);
   endtask

   task automatic expect_out(input int inst, input string name, input logic [3:0] q,
                             input logic w, input logic dis);
      push(inst, name, yexp(inst, q, dis), q, w);
   endtask

   task automatic check_front();
      exp_t        e;
      logic [15:0] ay;
      logic [3:0]  aq;
      logic        aw;
      if (sbq.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries, expected 1");
         return;
      end
      e = sbq.pop_front();
      case (e.inst)
         0:       begin ay = y0;            aq = q0;            aw = w0; end
         1:       begin ay = y1;            aq = q1;            aw = w1; end
         default: begin ay = {8'h00, y2};   aq = {1'b0, q2};    aw = w2; end
      endcase
      chk({e.name, "_Y"}, ay, e.y);
      chk({e.name, "_Q"}, {12'h000, aq}, {12'h000, e.q});
      chk({e.name, "_wrap"}, {15'h0000, aw}, {15'h0000, e.w});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_front();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] bq;
      int         bd;
      logic       bw;

      // {le, mode, _E0, _E1, A, Y, Q, wrap} for instance 0 (DWELL=1)
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1,  16'hFFFD, 4'd1,  1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 16'h7FFF, 4'd15, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  16'h7FFF, 4'd15, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 16'hBFFF, 4'd14, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'h7FFF, 4'd15, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'hFFFE, 4'd0,  1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'hFFFD, 4'd1,  1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  16'hFFFF, 4'd1,  1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 16'h7FFF, 4'd15, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd7,  16'hFF7F, 4'd7,  1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  16'hFF7F, 4'd7,  1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2,  16'hFFFF, 4'd2,  1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd9,  16'hFFFB, 4'd2,  1'b0};

      reset = 1'b1; reset2 = 1'b1;
      le0 = 0; mode0 = 0; ne0_0 = 0; ne1_0 = 0; a0 = '0;
      le1 = 0; mode1 = 0; ne0_1 = 0; ne1_1 = 0; a1 = '0;
      le2 = 0; mode2 = 0; ne0_2 = 0; ne1_2 = 0; a2 = '0;

      // reset state, both before and after a clock edge
      #1;
      push(0, "rst_async", 16'hFFFF, 4'd0, 1'b0); check_front();
      push(2, "rst_async2", 16'h00FF, 4'd0, 1'b0); check_front();
      push(0, "rst_clocked", 16'hFFFF, 4'd0, 1'b0); step();

      reset = 1'b0; reset2 = 1'b0;
      #1;
      push(0, "rst_release", 16'hFFFE, 4'd0, 1'b0); check_front();
      push(2, "rst_release2", 16'h00FE, 4'd0, 1'b0); check_front();
      ne0_0 = 1'b1;
      #1;
      push(0, "e0_gate", 16'hFFFF, 4'd0, 1'b0); check_front();
      ne0_0 = 1'b0;
      #1;
      push(0, "e0_ungate", 16'hFFFE, 4'd0, 1'b0); check_front();

      // latch / scan-wrap / simultaneous-load table on instance 0
      for (int i = 0; i < 13; i++) begin
         le0 = tbl[i].le; mode0 = tbl[i].mode; ne0_0 = tbl[i].ne0; ne1_0 = tbl[i].ne1;
         a0 = tbl[i].a;
         push(0, $sformatf("tbl%0d", i), tbl[i].y, tbl[i].q, tbl[i].w);
         step();
      end
      le0 = 0; mode0 = 0; ne0_0 = 0; ne1_0 = 0;

      // dwell and pause on instance 1 (DWELL=3)
      le1 = 1'b1; a1 = 4'd2;
      expect_out(1, "dw_load", 4'd2, 1'b0, 1'b0); step();
      le1 = 1'b0; mode1 = 1'b1;
      expect_out(1, "dw_a", 4'd2, 1'b0, 1'b0); step();
      expect_out(1, "dw_b", 4'd2, 1'b0, 1'b0); step();
      expect_out(1, "dw_c", 4'd3, 1'b0, 1'b0); step();
      expect_out(1, "dw_d", 4'd3, 1'b0, 1'b0); step();
      expect_out(1, "dw_e", 4'd3, 1'b0, 1'b0); step();
      expect_out(1, "dw_f", 4'd4, 1'b0, 1'b0); step();
      expect_out(1, "dw_g", 4'd4, 1'b0, 1'b0); step();
      ne1_1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         expect_out(1, $sformatf("pause%0d", k), 4'd4, 1'b0, 1'b1);
         step();
      end
      ne1_1 = 1'b0;
      expect_out(1, "resume_a", 4'd4, 1'b0, 1'b0); step();
      expect_out(1, "resume_b", 4'd5, 1'b0, 1'b0); step();
      expect_out(1, "resume_c", 4'd5, 1'b0, 1'b0); step();
      expect_out(1, "resume_d", 4'd5, 1'b0, 1'b0); step();
      le1 = 1'b1; a1 = 4'd7;
      expect_out(1, "simul_load", 4'd7, 1'b0, 1'b0); step();
      le1 = 1'b0;
      expect_out(1, "simul_hold_a", 4'd7, 1'b0, 1'b0); step();
      expect_out(1, "simul_hold_b", 4'd7, 1'b0, 1'b0); step();
      expect_out(1, "simul_next", 4'd8, 1'b0, 1'b0); step();
      mode1 = 1'b0;

      // asynchronous reset mid-scan on instance 2 (A_WIDTH=3, DWELL=2)
      le2 = 1'b1; a2 = 3'd4;
      expect_out(2, "ar_load", 4'd4, 1'b0, 1'b0); step();
      le2 = 1'b0; mode2 = 1'b1;
      expect_out(2, "ar_a", 4'd4, 1'b0, 1'b0); step();
      expect_out(2, "ar_b", 4'd5, 1'b0, 1'b0); step();
      #2;
      reset2 = 1'b1;
      #1;
      expect_out(2, "ar_mid", 4'd0, 1'b0, 1'b1); check_front();
      reset2 = 1'b0;
      #1;
      expect_out(2, "ar_rel", 4'd0, 1'b0, 1'b0); check_front();
      expect_out(2, "ar_d1", 4'd0, 1'b0, 1'b0); step();
      expect_out(2, "ar_d2", 4'd1, 1'b0, 1'b0); step();
      bq = 4'd1; bd = 0;
      for (int k = 0; k < 14; k++) begin
         bd++;
         bw = 1'b0;
         if (bd == 2) begin
            bd = 0;
            if (bq == 4'd7) bw = 1'b1;
            bq = (bq + 4'd1) & 4'd7;
         end
         expect_out(2, $sformatf("scan3_%0d", k), bq, bw, 1'b0);
         step();
      end

      if (sbq.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_decoder.md
# seq_decoder

Parametrised, registered successor to the 4-to-16 active-low decoder: decodes an A_WIDTH-bit address onto 2^A_WIDTH active-low select lines. The address is held in an internal register rather than decoded directly from the pins. The register is loaded from the A bus on a latch strobe, or stepped automatically through all outputs in scan mode with a programmable dwell time. It sits on the control-decode path and drives device-select and strobe lines, for example register-file enables and display-digit scanning.

## Interface
- A_WIDTH, default 4: address width. Output count is OUTS = 2^A_WIDTH.
- DWELL, default 1: clocks spent on each address in scan mode. Must be ≥1. Dwell counter width is $clog2(DWELL+1).
- clk  input  1  system clock. All state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- _E0  input  1  active-low enable. Combinational gating of Y.
- _E1  input  1  active-low enable. Combinational gating of Y.
- A  input  A_WIDTH  address to latch.
- le  input  1  latch enable, sampled at clk.
- mode  input  1  0 = MODE_LATCH, 1 = MODE_SCAN.
- Y  output  OUTS  active-low one-hot select.
- Q  output  A_WIDTH  current registered address.
- wrap  output  1  registered one-clock pulse on scan wrap from OUTS-1 to 0.

## Operation
- Enabled means _E0==0 && _E1==0.
- Y output:
  - While reset is asserted, or the block is not enabled: Y = all ones.
  - Otherwise: Y[i] = 0 exactly for i == Q.
- Registered state:
  - addr_q: drives Q.
  - dwell_q: dwell counter, 0..DWELL-1.
  - wrap_q: drives wrap.
- Per-edge priority, highest first:
  1. le==1: addr_q ← A; dwell_q ← 0. This applies in either mode and regardless of enables.
  2. mode==MODE_SCAN && enabled:
     - If dwell_q == DWELL-1: dwell_q ← 0 and addr_q ← addr_q+1, modulo OUTS.
     - Otherwise: dwell_q ← dwell_q+1.
  3. Anything else: hold addr_q and dwell_q.
- wrap_q ← 1 only on an edge where rule 2 advances addr_q from OUTS-1 to 0. Otherwise wrap_q ← 0. A load under rule 1 never raises wrap.
- Disabled during scan: the scan pauses with addr_q and dwell_q frozen, and resumes from the same point on re-enable.
- Mode changes:
  - Scan → latch: addr_q holds at its current value.
  - Latch → scan: the scan starts from the current addr_q. dwell_q keeps its value, which is always 0 after any load.
- DWELL==1: addr_q advances on every enabled scan edge.
- Address arithmetic is unsigned A_WIDTH bits. Wrap-around comes from natural overflow; no extra compare is needed.

## Timing
- Reset: addr_q=0, dwell_q=0, wrap_q=0. This acts immediately, with no clock required.
  - During reset: Y=all ones, Q=0, wrap=0.
  - The first edge after reset deasserts is a normal operating edge.
- Reset mid-scan: the scan aborts. After release it restarts from address 0 with the full dwell.
- Latency from loading A to Y: one clock, with the decode valid after the edge.
- Latency from _E0/_E1 to Y: combinational, zero clocks.
- In scan mode, each address is held for exactly DWELL enabled clocks. A full cycle takes OUTS×DWELL enabled clocks.
- wrap is high for exactly one clock, in the cycle where Q first reads 0 after the wrap.
- No output glitches on the registered outputs Q and wrap.

## Structure
- Shared package seq_decoder_pkg holds:
  - MODE_LATCH = 1'b0 and MODE_SCAN = 1'b1.
  - A helper function for the dwell counter width.
- Sub-module onehot_decode (parameter A_WIDTH) is the pure combinational active-low decoder: inputs addr and en, output y. Its unit bench is the existing fixed 4-to-16 decoder bench, generalised.
- The top level contains the address register, dwell counter, wrap flag and priority logic.

## Test plan
- Reset and enable gating, A_WIDTH=4:
  - Assert reset with both enables low → Y=16'hFFFF, Q=0.
  - Release reset → Y=16'hFFFE.
  - _E0=1 → Y=16'hFFFF immediately, with no clock.
- Latch mode: le=1 with A=1 → Y=16'hFFFD one edge later. With A=15 → Y=16'h7FFF. Then le=0 and A changes → Y unchanged.
- Scan wrap, DWELL=1:
  - Load 14, then mode=1 → Q steps 14, 15, 0, 1 on successive edges.
  - wrap is high only in the cycle Q=0.
  - Y moves through 16'hBFFF, 16'h7FFF, 16'hFFFE.
- Dwell and pause, DWELL=3:
  - Each Q value lasts 3 clocks.
  - Drive _E1=1 for 5 clocks mid-dwell → Q and the dwell count are frozen.
  - After re-enable, the remaining dwell clocks complete before the next step.
- Simultaneous events: in scan mode, raise le=1 with A=7 on the same edge a step or wrap is due → Q=7, wrap=0, and 7 is then held for a full DWELL.
- Asynchronous reset mid-scan, A_WIDTH=3, DWELL=2:
  - Assert reset between edges at Q=5 → Q=0 immediately.
  - After release → Q=0 for 2 clocks, then 1.
